// File: rtl/alu_writeback_stage.sv
// Two-entry writeback buffer between the combinational ALU and the register-file write port.
// Also holds the architectural NZCV status register and a retired-operation counter.
module alu_writeback_stage #(
  parameter int N     = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_answer,
  input  logic [N-1:0]     in_shiftR,
  input  logic             in_cout,
  input  logic             in_neg,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic             in_option,
  input  logic             in_sel_shift,
  input  logic             in_set_flags,
  input  logic [RADDR-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [RADDR-1:0] out_rd,
  output logic [3:0]       flags_nzcv,
  output logic [15:0]      op_count
);

  logic [N-1:0]     data_reg [2];
  logic [RADDR-1:0] rd_reg   [2];
  logic             head_reg;
  logic             tail_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [3:0]       nzcv_reg;
  logic [3:0]       nzcv_next;
  logic [15:0]      op_count_reg;
  logic             push;
  logic             pop;
  logic [N-1:0]     push_data;

  // in_ready looks only at registered state so upstream never sees a combinational path from out_ready
  assign in_ready  = rst && (count_reg != 2'd2);
  assign out_valid = rst && (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_data = in_sel_shift ? in_shiftR : in_answer;

  assign out_data   = out_valid ? data_reg[head_reg] : '0;
  assign out_rd     = out_valid ? rd_reg[head_reg] : '0;
  assign flags_nzcv = nzcv_reg;
  assign op_count   = op_count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_reg[gi] <= '0;
          rd_reg[gi]   <= '0;
        end else if (push && (tail_reg == gi[0])) begin
          data_reg[gi] <= push_data;
          rd_reg[gi]   <= in_rd;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Subtract carry is "no borrow", i.e. the inverse of the sign of the difference
  always_comb begin
    nzcv_next = nzcv_reg;
    if (push && in_set_flags) begin
      if (in_sel_shift) begin
        nzcv_next[3] = in_shiftR[N-1];
        nzcv_next[2] = (in_shiftR == '0);
      end else begin
        nzcv_next[3] = in_neg;
        nzcv_next[2] = in_zero;
        nzcv_next[1] = in_option ? ~in_neg : in_cout;
        nzcv_next[0] = in_overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
      count_reg    <= 2'd0;
      nzcv_reg     <= 4'b0000;
      op_count_reg <= 16'd0;
    end else begin
      count_reg <= count_next;
      nzcv_reg  <= nzcv_next;
      if (push) tail_reg <= ~tail_reg;
      if (pop) begin
        head_reg     <= ~head_reg;
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: linear steps, immediate assertions at each check.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_answer;
  logic [31:0] in_shiftR;
  logic        in_cout, in_neg, in_zero, in_overflow;
  logic        in_option, in_sel_shift, in_set_flags;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_rd;
  logic [3:0]  flags_nzcv;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fails  = 0;

  alu_writeback_stage #(.N(32), .RADDR(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_answer   (in_answer),
    .in_shiftR   (in_shiftR),
    .in_cout     (in_cout),
    .in_neg      (in_neg),
    .in_zero     (in_zero),
    .in_overflow (in_overflow),
    .in_option   (in_option),
    .in_sel_shift(in_sel_shift),
    .in_set_flags(in_set_flags),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .flags_nzcv  (flags_nzcv),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic offer(input logic [31:0] ans, input logic [31:0] shr, input logic [3:0] rd,
                       input logic sel, input logic setf, input logic opt,
                       input logic n, input logic z, input logic c, input logic v);
    in_valid     = 1'b1;
    in_answer    = ans;
    in_shiftR    = shr;
    in_rd        = rd;
    in_sel_shift = sel;
    in_set_flags = setf;
    in_option    = opt;
    in_neg       = n;
    in_zero      = z;
    in_cout      = c;
    in_overflow  = v;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    offer(32'hDEAD_BEEF, 32'hFFFF_0000, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held for three edges with upstream offering data
    tick(); tick(); tick();
    $display("step reset held");
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", {28'd0, out_rd}, 32'd0);
    check("rst_flags", {28'd0, flags_nzcv}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    $display("step reset released");
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Add with flags: zero result, carry out
    offer(32'h0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("step add push rd=3");
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_out_data", out_data, 32'd0);
    check("add_out_rd", {28'd0, out_rd}, 32'd3);
    check("add_flags", {28'd0, flags_nzcv}, 32'b0110);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("step add pop");
    check("add_op_count", {16'd0, op_count}, 32'd1);
    check("add_empty", {31'd0, out_valid}, 32'd0);

    // Subtract with borrow, then a push that leaves flags alone
    offer(32'h2, 32'h0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    $display("step sub push rd=5");
    check("sub_flags", {28'd0, flags_nzcv}, 32'b1000);
    check("sub_out_data", out_data, 32'd2);
    offer(32'h7, 32'h0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    $display("step push no-flags rd=6");
    check("noflag_flags", {28'd0, flags_nzcv}, 32'b1000);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head_data", out_data, 32'd2);
    check("full_head_rd", {28'd0, out_rd}, 32'd5);
    out_ready = 1'b1;
    tick();
    $display("step pop head");
    check("pop2_data", out_data, 32'd7);
    check("pop2_rd", {28'd0, out_rd}, 32'd6);
    tick();
    out_ready = 1'b0;
    $display("step pop second");
    check("pop2_op_count", {16'd0, op_count}, 32'd3);

    // Establish flags 0011, then shift result updates only N and Z
    out_ready = 1'b1;
    offer(32'h10, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    $display("step add push flags=0011");
    check("pre_shift_flags", {28'd0, flags_nzcv}, 32'b0011);
    check("pre_shift_in_ready", {31'd0, in_ready}, 32'd1);
    offer(32'h5, 32'hC000_0000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("step shift push with simultaneous pop");
    check("shift_out_data", out_data, 32'hC000_0000);
    check("shift_out_rd", {28'd0, out_rd}, 32'd2);
    check("shift_flags", {28'd0, flags_nzcv}, 32'b1011);
    check("shift_op_count", {16'd0, op_count}, 32'd4);
    check("shift_count1", {31'd0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("shift_drain", {31'd0, out_valid}, 32'd0);
    check("shift_drain_op", {16'd0, op_count}, 32'd5);

    // Backpressure: fill, offer a third entry that must be ignored
    offer(32'h11, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    offer(32'h22, 32'h0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    $display("step backpressure full");
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    offer(32'h33, 32'h0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    $display("step offer 0x33 while full");
    check("bp_hold_data", out_data, 32'h11);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_flags_ignored", {28'd0, flags_nzcv}, 32'b1011);
    out_ready = 1'b1;
    tick();
    $display("step pop 0x11");
    check("bp_second", out_data, 32'h22);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    offer(32'h33, 32'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("step push 0x33 with pop 0x22");
    check("bp_third", out_data, 32'h33);
    check("bp_third_rd", {28'd0, out_rd}, 32'd3);
    check("bp_count1", {31'd0, in_ready}, 32'd1);
    check("bp_op_count", {16'd0, op_count}, 32'd7);
    tick();
    check("bp_drain_op", {16'd0, op_count}, 32'd8);

    // Wrap: 65528 more pops bring the counter from 8 back to 0
    in_set_flags = 1'b0;
    in_sel_shift = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 65528; i++) begin
      in_answer = i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    $display("step 65528 streamed pops");
    check("wrap_op_count", {16'd0, op_count}, 32'd0);
    check("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered
    out_ready = 1'b0;
    offer(32'hAA, 32'h0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_answer = 32'hBB;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    $display("step reset while full");
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_op", {16'd0, op_count}, 32'd0);
    check("midrst_flags", {28'd0, flags_nzcv}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("midrst_lost", {31'd0, out_valid}, 32'd0);
    check("midrst_no_pop", {16'd0, op_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
